if_fetch_unit: RTL and testbench



---
 rtl/if_fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_if_fetch_unit.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, talks to imem with a req/ack
// handshake and presents if_pc/if_inst to the IF/ID register.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned MAX_WAIT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall,
   input  logic        flush,
   input  logic [31:0] new_pc,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_target_address_i,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        stallreq_if,
   output logic        fetch_err
);

   typedef enum logic [1:0] {
      ST_RST,
      ST_REQ,
      ST_VALID,
      ST_DROP
   } state_t;

   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic        pend_br_q, pend_br_d;
   logic [31:0] pend_tgt_q, pend_tgt_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic        imem_req_q, imem_req_d;
   logic [31:0] imem_addr_q, imem_addr_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic [31:0] if_inst_q, if_inst_d;
   logic        stallreq_q, stallreq_d;
   logic        fetch_err_q, fetch_err_d;
   logic        consume;
   logic        enter_req;
   logic        cont_wait;
   logic        stall_unused;

   // only stall[1] gates the IF/ID register
   assign stall_unused = ^{stall[5:2], stall[0]};
   assign consume = (state_q == ST_VALID) && !stall[1];

   // next-state, PC, branch bookkeeping and registered output values
   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      pend_br_d   = pend_br_q;
      pend_tgt_d  = pend_tgt_q;
      if_pc_d     = if_pc_q;
      if_inst_d   = if_inst_q;
      imem_addr_d = imem_addr_q;
      enter_req   = 1'b0;
      cont_wait   = 1'b0;
      if (branch_flag_i) begin
         pend_br_d  = 1'b1;
         pend_tgt_d = branch_target_address_i;
      end
      case (state_q)
         ST_RST: state_d = ST_REQ;
         ST_REQ: begin
            if (imem_ack) begin
               if_inst_d = imem_rdata;
               if_pc_d   = fetch_pc_q;
               state_d   = ST_VALID;
            end
         end
         ST_VALID: begin
            if (consume) begin
               state_d   = ST_REQ;
               pend_br_d = 1'b0;
               if (branch_flag_i)
                  fetch_pc_d = branch_target_address_i;
               else if (pend_br_q)
                  fetch_pc_d = pend_tgt_q;
               else
                  fetch_pc_d = fetch_pc_q + 32'd4;
            end
         end
         ST_DROP: begin
            if (imem_ack)
               state_d = ST_REQ;
         end
         default: state_d = ST_RST;
      endcase
      // an unacked request is still owed by memory, so drain it
      if (flush && state_q != ST_RST) begin
         fetch_pc_d = new_pc;
         pend_br_d  = 1'b0;
         pend_tgt_d = pend_tgt_q;
         if_inst_d  = '0;
         if_pc_d    = '0;
         if (state_q != ST_VALID && !imem_ack)
            state_d = ST_DROP;
         else
            state_d = ST_REQ;
      end
      enter_req = (state_d == ST_REQ) &&
                  (state_q != ST_REQ || imem_ack);
      if (enter_req) begin
         imem_addr_d = {fetch_pc_d[31:2], 2'b00};
         if_inst_d   = '0;
      end
      imem_req_d = (state_d == ST_REQ) || (state_d == ST_DROP);
      stallreq_d = imem_req_d;
      cont_wait  = imem_req_d && (state_d == state_q) && !imem_ack;
      if (!cont_wait)
         wait_cnt_d = '0;
      else if (wait_cnt_q == WAIT_LAST)
         wait_cnt_d = wait_cnt_q;
      else
         wait_cnt_d = wait_cnt_q + 8'd1;
      fetch_err_d = imem_req_d && (wait_cnt_d == WAIT_LAST) &&
                    !(cont_wait && wait_cnt_q == WAIT_LAST);
   end

   // state and output registers, synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RST;
         fetch_pc_q  <= RESET_PC;
         pend_br_q   <= 1'b0;
         pend_tgt_q  <= '0;
         wait_cnt_q  <= '0;
         imem_req_q  <= 1'b0;
         imem_addr_q <= '0;
         if_pc_q     <= '0;
         if_inst_q   <= '0;
         stallreq_q  <= 1'b0;
         fetch_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         pend_br_q   <= pend_br_d;
         pend_tgt_q  <= pend_tgt_d;
         wait_cnt_q  <= wait_cnt_d;
         imem_req_q  <= imem_req_d;
         imem_addr_q <= imem_addr_d;
         if_pc_q     <= if_pc_d;
         if_inst_q   <= if_inst_d;
         stallreq_q  <= stallreq_d;
         fetch_err_q <= fetch_err_d;
      end
   end

   assign imem_req    = imem_req_q;
   assign imem_addr   = imem_addr_q;
   assign if_pc       = if_pc_q;
   assign if_inst     = if_inst_q;
   assign stallreq_if = stallreq_q;
   assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: vector table for streaming fetch, scoreboard
// of acked words, hand-written stall/branch/flush/timeout/reset sequences.
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        branch_flag_i;
   logic [31:0] branch_target_address_i;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        stallreq_if;
   logic        fetch_err;
   logic        fetch_err4;
   logic        u4_unused_req;
   logic [31:0] u4_unused_addr;
   logic [31:0] u4_unused_pc;
   logic [31:0] u4_unused_inst;
   logic        u4_unused_streq;

   logic        ack_tie;
   logic        ack_drv;
   logic [31:0] rdata_drv;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } sb_t;
   sb_t sbq[$];

   typedef struct {
      logic [5:0]  stall;
      logic        req;
      logic [31:0] addr;
      logic        streq;
      logic [31:0] pc;
      logic [31:0] inst;
   } vec_t;
   vec_t vt[8];

   always #5 clk = ~clk;

   function automatic logic [31:0] fdat(input logic [31:0] a);
      return a ^ 32'hC0DE_0013;
   endfunction

   assign imem_ack   = ack_tie ? imem_req : ack_drv;
   assign imem_rdata = ack_tie ? fdat(imem_addr) : rdata_drv;

   if_fetch_unit dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .new_pc(new_pc), .branch_flag_i(branch_flag_i),
      .branch_target_address_i(branch_target_address_i),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .if_pc(if_pc), .if_inst(if_inst),
      .stallreq_if(stallreq_if), .fetch_err(fetch_err)
   );

   if_fetch_unit #(.RESET_PC(32'h0), .MAX_WAIT(4)) dut4 (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .new_pc(new_pc), .branch_flag_i(branch_flag_i),
      .branch_target_address_i(branch_target_address_i),
      .imem_req(u4_unused_req), .imem_addr(u4_unused_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .if_pc(u4_unused_pc), .if_inst(u4_unused_inst),
      .stallreq_if(u4_unused_streq), .fetch_err(fetch_err4)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] pc, input logic [31:0] inst);
      sb_t e;
      e.pc   = pc;
      e.inst = inst;
      sbq.push_back(e);
   endtask

   task automatic pop_chk(input string name);
      sb_t e;
      if (sbq.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: got empty scoreboard expected entry", name);
      end else begin
         e = sbq.pop_front();
         chk({name, ".pc"}, if_pc, e.pc);
         chk({name, ".inst"}, if_inst, e.inst);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vt[0] = '{6'd0, 1'b1, 32'h0, 1'b1, 32'h0, 32'h0};
      vt[1] = '{6'd0, 1'b0, 32'h0, 1'b0, 32'h0, fdat(32'h0)};
      vt[2] = '{6'd0, 1'b1, 32'h4, 1'b1, 32'h0, 32'h0};
      vt[3] = '{6'd0, 1'b0, 32'h4, 1'b0, 32'h4, fdat(32'h4)};
      vt[4] = '{6'd0, 1'b1, 32'h8, 1'b1, 32'h4, 32'h0};
      vt[5] = '{6'd0, 1'b0, 32'h8, 1'b0, 32'h8, fdat(32'h8)};
      vt[6] = '{6'd0, 1'b1, 32'hC, 1'b1, 32'h8, 32'h0};
      vt[7] = '{6'd0, 1'b0, 32'hC, 1'b0, 32'hC, fdat(32'hC)};

      rst = 1'b1; stall = '0; flush = 1'b0; new_pc = '0;
      branch_flag_i = 1'b0; branch_target_address_i = '0;
      ack_tie = 1'b0; ack_drv = 1'b0; rdata_drv = '0;
      repeat (3) tick();
      chk("rst.req", imem_req, 1'b0);
      chk("rst.addr", imem_addr, 32'h0);
      chk("rst.pc", if_pc, 32'h0);
      chk("rst.inst", if_inst, 32'h0);
      chk("rst.streq", stallreq_if, 1'b0);
      chk("rst.err", fetch_err, 1'b0);

      // zero-wait streaming fetch
      rst = 1'b0;
      ack_tie = 1'b1;
      for (int i = 0; i < 8; i++) begin
         stall = vt[i].stall;
         tick();
         chk($sformatf("t1[%0d].req", i), imem_req, vt[i].req);
         chk($sformatf("t1[%0d].addr", i), imem_addr, vt[i].addr);
         chk($sformatf("t1[%0d].streq", i), stallreq_if, vt[i].streq);
         chk($sformatf("t1[%0d].pc", i), if_pc, vt[i].pc);
         chk($sformatf("t1[%0d].inst", i), if_inst, vt[i].inst);
      end
      ack_tie = 1'b0;

      // three wait states on fetch at 0x10
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk($sformatf("t2.w%0d.streq", k), stallreq_if, 1'b1);
         chk($sformatf("t2.w%0d.inst", k), if_inst, 32'h0);
         chk($sformatf("t2.w%0d.addr", k), imem_addr, 32'h10);
         chk($sformatf("t2.w%0d.err", k), fetch_err, 1'b0);
         if (k == 4) begin
            ack_drv = 1'b1;
            rdata_drv = 32'h1234_5678;
            push(32'h10, 32'h1234_5678);
         end
      end
      tick();
      ack_drv = 1'b0;
      pop_chk("t2.present");
      chk("t2.streq", stallreq_if, 1'b0);

      // IF/ID stall holds the presented instruction
      stall = 6'b000011;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk($sformatf("t3.h%0d.pc", k), if_pc, 32'h10);
         chk($sformatf("t3.h%0d.inst", k), if_inst, 32'h1234_5678);
         chk($sformatf("t3.h%0d.req", k), imem_req, 1'b0);
      end
      stall = '0;
      tick();
      chk("t3.next_addr", imem_addr, 32'h14);

      // branch during delay-slot fetch
      branch_flag_i = 1'b1;
      branch_target_address_i = 32'h100;
      tick();
      branch_flag_i = 1'b0;
      chk("t4.addr_stable", imem_addr, 32'h14);
      ack_drv = 1'b1; rdata_drv = 32'hAAAA_0001;
      push(32'h14, 32'hAAAA_0001);
      tick();
      ack_drv = 1'b0;
      pop_chk("t4.slot");
      tick();
      chk("t4.target", imem_addr, 32'h100);
      ack_drv = 1'b1; rdata_drv = 32'hAAAA_0002;
      push(32'h100, 32'hAAAA_0002);
      tick();
      ack_drv = 1'b0;
      pop_chk("t4.tgt_inst");
      branch_flag_i = 1'b1;
      branch_target_address_i = 32'h200;
      tick();
      branch_flag_i = 1'b0;
      chk("t4.direct", imem_addr, 32'h200);

      // flush while a request is outstanding
      tick();
      flush = 1'b1; new_pc = 32'h180;
      tick();
      flush = 1'b0;
      chk("t5.drop.req", imem_req, 1'b1);
      chk("t5.drop.streq", stallreq_if, 1'b1);
      chk("t5.drop.addr", imem_addr, 32'h200);
      chk("t5.drop.inst", if_inst, 32'h0);
      chk("t5.drop.pc", if_pc, 32'h0);
      tick();
      chk("t5.drop2.inst", if_inst, 32'h0);
      ack_drv = 1'b1; rdata_drv = 32'hDEAD_BEEF;
      tick();
      ack_drv = 1'b0;
      chk("t5.redir", imem_addr, 32'h180);
      chk("t5.no_stale", if_inst, 32'h0);
      ack_drv = 1'b1; rdata_drv = 32'hAAAA_0003;
      push(32'h180, 32'hAAAA_0003);
      tick();
      ack_drv = 1'b0;
      pop_chk("t5.handler");
      tick();
      chk("t5.seq", imem_addr, 32'h184);

      // flush with ack and branch in the same cycle
      ack_drv = 1'b1; rdata_drv = 32'h5555_AAAA;
      flush = 1'b1; new_pc = 32'h300;
      branch_flag_i = 1'b1; branch_target_address_i = 32'h400;
      tick();
      ack_drv = 1'b0; flush = 1'b0; branch_flag_i = 1'b0;
      chk("t5b.addr", imem_addr, 32'h300);
      chk("t5b.inst", if_inst, 32'h0);
      chk("t5b.pc", if_pc, 32'h0);
      chk("t5b.req", imem_req, 1'b1);
      ack_drv = 1'b1; rdata_drv = 32'hAAAA_0005;
      push(32'h300, 32'hAAAA_0005);
      tick();
      ack_drv = 1'b0;
      pop_chk("t5b.present");
      tick();
      chk("t5b.no_branch", imem_addr, 32'h304);

      // timeout: fetch_err in 4th waiting cycle with MAX_WAIT=4
      for (int k = 1; k <= 10; k++) begin
         if (k > 1) tick();
         chk($sformatf("t6.c%0d.err4", k), fetch_err4, (k == 4));
         chk($sformatf("t6.c%0d.err", k), fetch_err, 1'b0);
         chk($sformatf("t6.c%0d.req", k), imem_req, 1'b1);
      end
      ack_drv = 1'b1; rdata_drv = 32'hAAAA_0006;
      push(32'h304, 32'hAAAA_0006);
      tick();
      ack_drv = 1'b0;
      pop_chk("t6.late_ack");
      chk("t6.err4_low", fetch_err4, 1'b0);

      // reset mid-operation; ack during ST_RST ignored
      rst = 1'b1;
      ack_drv = 1'b1; rdata_drv = 32'hBAD0_BAD0;
      tick();
      chk("t7.req", imem_req, 1'b0);
      chk("t7.addr", imem_addr, 32'h0);
      chk("t7.pc", if_pc, 32'h0);
      chk("t7.inst", if_inst, 32'h0);
      chk("t7.streq", stallreq_if, 1'b0);
      rst = 1'b0;
      tick();
      ack_drv = 1'b0;
      chk("t7.rst_ack.req", imem_req, 1'b1);
      chk("t7.rst_ack.addr", imem_addr, 32'h0);
      chk("t7.rst_ack.inst", if_inst, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
